// File: rtl/chip8_mem_arbiter_if.sv
// chip8_mem_arbiter_if: requester and memory-side signals of the CHIP-8 memory arbiter
interface chip8_mem_arbiter_if;
    logic        proc_valid_in;
    logic [11:0] proc_addr_in;
    logic        proc_we_in;
    logic [1:0]  proc_type_in;
    logic [15:0] proc_wdata_in;
    logic        proc_ready_out;
    logic        proc_rvalid_out;
    logic        video_valid_in;
    logic [11:0] video_addr_in;
    logic        video_ready_out;
    logic        video_rvalid_out;
    logic        debug_valid_in;
    logic [11:0] debug_addr_in;
    logic        debug_we_in;
    logic [1:0]  debug_type_in;
    logic [15:0] debug_wdata_in;
    logic        debug_ready_out;
    logic        debug_rvalid_out;
    logic [15:0] data_out;
    logic [11:0] mem_addr_out;
    logic        mem_we_out;
    logic [7:0]  mem_din_out;
    logic [7:0]  mem_dout_in;

    modport slave (
        input  proc_valid_in, proc_addr_in, proc_we_in, proc_type_in, proc_wdata_in,
        input  video_valid_in, video_addr_in,
        input  debug_valid_in, debug_addr_in, debug_we_in, debug_type_in, debug_wdata_in,
        input  mem_dout_in,
        output proc_ready_out, proc_rvalid_out, video_ready_out, video_rvalid_out,
        output debug_ready_out, debug_rvalid_out, data_out,
        output mem_addr_out, mem_we_out, mem_din_out
    );

    modport master (
        output proc_valid_in, proc_addr_in, proc_we_in, proc_type_in, proc_wdata_in,
        output video_valid_in, video_addr_in,
        output debug_valid_in, debug_addr_in, debug_we_in, debug_type_in, debug_wdata_in,
        output mem_dout_in,
        input  proc_ready_out, proc_rvalid_out, video_ready_out, video_rvalid_out,
        input  debug_ready_out, debug_rvalid_out, data_out,
        input  mem_addr_out, mem_we_out, mem_din_out
    );
endinterface

// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter: shares the byte-wide CHIP-8 memory among debug, proc and video requesters
module chip8_mem_arbiter #(
    parameter int MEM_LATENCY    = 2,
    parameter int VIDEO_MAX_WAIT = 8
) (
    input logic                clk_in,
    input logic                rst_in,
    chip8_mem_arbiter_if.slave bus
);
    localparam int WW = $clog2(VIDEO_MAX_WAIT + 2);
    localparam logic [WW-1:0] VMAX = WW'(VIDEO_MAX_WAIT);
    localparam logic [1:0] ID_PROC  = 2'd0;
    localparam logic [1:0] ID_VIDEO = 2'd1;
    localparam logic [1:0] ID_DEBUG = 2'd2;

    typedef enum logic {IDLE, BEAT1} state_t;
    typedef struct packed {logic valid; logic [1:0] id; logic hi; logic last;} tag_t;

    state_t        state, state_nxt;
    logic [WW-1:0] video_wait;
    logic [11:0]   b1_addr;
    logic          b1_we;
    logic [7:0]    b1_din;
    logic [1:0]    b1_id;
    tag_t          tags [MEM_LATENCY];
    tag_t          tag_in, tag_out;
    logic [7:0]    hi_byte;
    logic          hi_pend;
    logic          g_debug, g_proc, g_video, issue, beat1, word, sel_we;
    logic [11:0]   sel_addr;
    logic [15:0]   sel_wdata;
    logic [1:0]    sel_id;

    assign tag_out = tags[MEM_LATENCY-1];

    // grant arbitration, beat issue to memory and read-tag generation
    always_comb begin
        g_debug   = !rst_in && state == IDLE && bus.debug_valid_in;
        g_video   = !rst_in && state == IDLE && !bus.debug_valid_in && bus.video_valid_in &&
                    (video_wait == VMAX || !bus.proc_valid_in);
        g_proc    = !rst_in && state == IDLE && !bus.debug_valid_in && bus.proc_valid_in && !g_video;
        issue     = g_debug || g_proc || g_video;
        beat1     = !rst_in && state == BEAT1;
        sel_id    = g_debug ? ID_DEBUG : g_proc ? ID_PROC : ID_VIDEO;
        sel_addr  = g_debug ? bus.debug_addr_in : g_proc ? bus.proc_addr_in : bus.video_addr_in;
        sel_we    = g_debug ? bus.debug_we_in : g_proc && bus.proc_we_in;
        sel_wdata = g_debug ? bus.debug_wdata_in : bus.proc_wdata_in;
        word      = g_debug ? bus.debug_type_in == 2'd1 : g_proc && bus.proc_type_in == 2'd1;
        state_nxt = issue && word ? BEAT1 : IDLE;
        bus.debug_ready_out = g_debug;
        bus.proc_ready_out  = g_proc;
        bus.video_ready_out = g_video;
        bus.mem_addr_out = beat1 ? b1_addr + 12'd1 : issue ? sel_addr : 12'd0;
        bus.mem_we_out   = beat1 ? b1_we : issue && sel_we;
        bus.mem_din_out  = beat1 ? b1_din : word ? sel_wdata[15:8] : sel_wdata[7:0];
        tag_in.valid = beat1 ? !b1_we : issue && !sel_we;
        tag_in.id    = beat1 ? b1_id : sel_id;
        tag_in.hi    = !beat1 && word;
        tag_in.last  = beat1 || !word;
    end

    // FSM state, plus the low-byte beat context captured when a word is accepted
    always_ff @(posedge clk_in) begin
        state <= rst_in ? IDLE : state_nxt;
        if (issue && word) begin
            b1_addr <= sel_addr;
            b1_we   <= sel_we;
            b1_din  <= sel_wdata[7:0];
            b1_id   <= sel_id;
        end
    end

    // tag pipeline aligned to memory latency; assembles read data and pulses rvalid on the last beat
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < MEM_LATENCY; i++) tags[i] <= '0;
            hi_byte              <= 8'h00;
            hi_pend              <= 1'b0;
            bus.data_out         <= 16'h0000;
            bus.proc_rvalid_out  <= 1'b0;
            bus.video_rvalid_out <= 1'b0;
            bus.debug_rvalid_out <= 1'b0;
        end else begin
            tags[0] <= tag_in;
            for (int i = 1; i < MEM_LATENCY; i++) tags[i] <= tags[i-1];
            hi_pend <= tag_out.valid && tag_out.hi;
            if (tag_out.valid && tag_out.hi) hi_byte <= bus.mem_dout_in;
            if (tag_out.valid && tag_out.last) bus.data_out <= {hi_pend ? hi_byte : 8'h00, bus.mem_dout_in};
            bus.proc_rvalid_out  <= tag_out.valid && tag_out.last && tag_out.id == ID_PROC;
            bus.video_rvalid_out <= tag_out.valid && tag_out.last && tag_out.id == ID_VIDEO;
            bus.debug_rvalid_out <= tag_out.valid && tag_out.last && tag_out.id == ID_DEBUG;
        end
    end

    // video starvation counter: counts stalled cycles, saturating at VIDEO_MAX_WAIT
    always_ff @(posedge clk_in) begin
        if (rst_in || !bus.video_valid_in || g_video) video_wait <= '0;
        else if (video_wait != VMAX) video_wait <= video_wait + 1'b1;
    end
endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// tb_chip8_mem_arbiter: randomized scoreboard bench for the CHIP-8 memory arbiter
module tb_chip8_mem_arbiter;
    localparam int L    = 2;
    localparam int VMAX = 8;

    typedef struct {int id; logic [15:0] data; int due;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load = 1'b1;
    always #5 clk = ~clk;

    chip8_mem_arbiter_if bus();
    chip8_mem_arbiter #(.MEM_LATENCY(L), .VIDEO_MAX_WAIT(VMAX)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));

    logic [7:0] gold [4096];
    logic [7:0] mem  [4096];
    logic [7:0] rd_pipe [L];

    // memory array with fixed read latency; preloaded from the reference image
    always @(posedge clk) begin
        if (load) for (int i = 0; i < 4096; i++) mem[i] <= gold[i];
        else if (bus.mem_we_out) mem[bus.mem_addr_out] <= bus.mem_din_out;
        rd_pipe[0] <= mem[bus.mem_addr_out];
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_dout_in = rd_pipe[L-1];

    int         cyc = 0, checks = 0, errors = 0;
    int         acc_cyc [3];
    logic [2:0] pend = 3'b000;
    logic [11:0] r_addr [3];
    logic        r_we [3];
    logic [1:0]  r_type [3];
    logic [15:0] r_wdata [3];
    logic        rst_req = 1'b1, rst_was = 1'b0, started = 1'b0;
    logic        m_busy = 1'b0, m_we = 1'b0;
    logic [11:0] m_addr = '0;
    logic [7:0]  m_din = '0;
    int          m_vw = 0;
    exp_t        sb [$];
    exp_t        mon_e;
    logic [2:0]  mon_rv;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic req(int r, logic [11:0] a, logic we, logic [1:0] t, logic [15:0] d);
        pend[r]    = 1'b1;
        r_addr[r]  = a;
        r_we[r]    = r == 1 ? 1'b0 : we;
        r_type[r]  = r == 1 ? 2'd0 : t;
        r_wdata[r] = d;
    endtask

    task automatic drive();
        bus.proc_valid_in  = pend[0];
        bus.proc_addr_in   = r_addr[0];
        bus.proc_we_in     = r_we[0];
        bus.proc_type_in   = r_type[0];
        bus.proc_wdata_in  = r_wdata[0];
        bus.video_valid_in = pend[1];
        bus.video_addr_in  = r_addr[1];
        bus.debug_valid_in = pend[2];
        bus.debug_addr_in  = r_addr[2];
        bus.debug_we_in    = r_we[2];
        bus.debug_type_in  = r_type[2];
        bus.debug_wdata_in = r_wdata[2];
    endtask

    // one clock: drive after the edge, then check grant/beat against the model at the falling edge
    task automatic tick();
        int          w;
        logic        word;
        logic [11:0] ea, a1;
        logic        ewe;
        logic [7:0]  ed;
        @(posedge clk);
        cyc++;
        if (rst_was) begin
            sb.delete();
            rst_was = 1'b0;
        end
        #1;
        load = 1'b0;
        rst = rst_req;
        drive();
        @(negedge clk);
        w = -1;
        if (!rst && !m_busy) begin
            if (pend[2]) w = 2;
            else if (pend[1] && (m_vw == VMAX || !pend[0])) w = 1;
            else if (pend[0]) w = 0;
        end
        check("ready", {bus.debug_ready_out, bus.video_ready_out, bus.proc_ready_out},
              w < 0 ? 0 : 1 << w);
        word = w >= 0 && r_type[w] == 2'd1;
        if (rst) begin ea = 0; ewe = 0; ed = 0; end
        else if (m_busy) begin ea = m_addr; ewe = m_we; ed = m_din; end
        else if (w >= 0) begin
            ea = r_addr[w]; ewe = r_we[w];
            ed = word ? r_wdata[w][15:8] : r_wdata[w][7:0];
        end
        else begin ea = 0; ewe = 0; ed = 0; end
        check("beat", {bus.mem_addr_out, bus.mem_we_out, bus.mem_we_out ? bus.mem_din_out : 8'h00},
              {ea, ewe, ewe ? ed : 8'h00});
        m_busy = !rst && word;
        if (word) begin
            m_addr = r_addr[w] + 12'd1;
            m_we   = r_we[w];
            m_din  = r_wdata[w][7:0];
        end
        m_vw = (rst || !pend[1] || w == 1) ? 0 : (m_vw < VMAX ? m_vw + 1 : VMAX);
        if (w >= 0) begin
            acc_cyc[w] = cyc;
            a1 = r_addr[w] + 12'd1;
            if (r_we[w]) begin
                if (word) begin
                    gold[r_addr[w]] = r_wdata[w][15:8];
                    gold[a1] = r_wdata[w][7:0];
                end else gold[r_addr[w]] = r_wdata[w][7:0];
            end else
                sb.push_back('{id: w, data: word ? {gold[r_addr[w]], gold[a1]} : {8'h00, gold[r_addr[w]]},
                               due: cyc + L + 1 + (word ? 1 : 0)});
            pend[w] = 1'b0;
        end
        if (rst) rst_was = 1'b1;
    endtask

    task automatic settle(int budget);
        int n = 0;
        while ((pend != 0 || m_busy || sb.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("settle_in_budget", n < budget, 1);
    endtask

    // monitor: every rvalid pops the scoreboard and must match requester, data and cycle
    always @(negedge clk) begin
        if (started) begin
            mon_rv = {bus.debug_rvalid_out, bus.video_rvalid_out, bus.proc_rvalid_out};
            if (sb.size() != 0 && sb[0].due < cyc) begin
                mon_e = sb.pop_front();
                check("rvalid_missing", cyc, mon_e.due);
            end
            if (mon_rv != 0) begin
                if (sb.size() == 0) check("rvalid_unexpected", {29'b0, mon_rv}, 0);
                else begin
                    mon_e = sb.pop_front();
                    check("rvalid_id", {29'b0, mon_rv}, 1 << mon_e.id);
                    check("rdata", {16'h0, bus.data_out}, {16'h0, mon_e.data});
                    check("rvalid_cycle", cyc, mon_e.due);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int s, first;
        for (int i = 0; i < 4096; i++) gold[i] = 8'($urandom);
        gold[12'h201] = 8'hE0;
        for (int r = 0; r < 3; r++) begin
            r_addr[r] = '0; r_we[r] = 1'b0; r_type[r] = '0; r_wdata[r] = '0;
        end
        drive();
        tick(); tick();
        rst_req = 1'b0;
        tick();
        started = 1'b1;
        check("reset_outputs", {bus.proc_rvalid_out, bus.video_rvalid_out, bus.debug_rvalid_out,
              bus.data_out, bus.mem_we_out, bus.mem_addr_out}, 0);

        req(2, 12'h201, 1'b0, 2'd0, 16'h0);
        settle(20);

        req(0, 12'hFFF, 1'b1, 2'd1, 16'hABCD);
        settle(20);
        req(0, 12'hFFF, 1'b0, 2'd1, 16'h0);
        settle(20);

        req(2, 12'h010, 1'b0, 2'd0, 16'h0);
        req(0, 12'h020, 1'b0, 2'd2, 16'h0);
        req(1, 12'h030, 1'b0, 2'd0, 16'h0);
        settle(20);
        check("accept_order", {16'(acc_cyc[0] - acc_cyc[2]), 16'(acc_cyc[1] - acc_cyc[0])}, {16'd1, 16'd1});

        for (int k = 0; k < 2; k++) begin
            req(1, 12'h400 + 12'(k), 1'b0, 2'd0, 16'h0);
            s = cyc + 1;
            for (int n = 0; n < 30 && pend[1]; n++) begin
                if (!pend[0]) req(0, 12'($urandom), 1'b0, 2'd0, 16'h0);
                tick();
            end
            check("video_stall", acc_cyc[1] - s, VMAX);
        end
        settle(30);

        req(2, 12'h123, 1'b0, 2'd1, 16'h0);
        tick();
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        tick();
        check("midop_reset_outputs", {bus.proc_rvalid_out, bus.video_rvalid_out, bus.debug_rvalid_out,
              bus.data_out, bus.mem_we_out, bus.mem_addr_out}, 0);
        repeat (8) tick();

        first = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            req(1, 12'h300 + 12'(k), 1'b0, 2'd0, 16'h0);
            tick();
        end
        check("video_b2b", acc_cyc[1] - first, 3);
        settle(20);

        for (int n = 0; n < 1500; n++) begin
            for (int r = 0; r < 3; r++)
                if (!pend[r] && $urandom_range(0, 99) < 35)
                    req(r, $urandom_range(0, 7) == 0 ? 12'hFFF : 12'($urandom), 1'($urandom_range(0, 1)),
                        2'($urandom_range(0, 3)), 16'($urandom));
            rst_req = $urandom_range(0, 299) == 0;
            tick();
        end
        rst_req = 1'b0;
        settle(200);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/chip8_mem_arbiter.md
Name: chip8_mem_arbiter

Overview:
Shares the single-port, byte-wide CHIP-8 memory between three requesters: processor, video fetch, and debug/loader. It grants one memory beat per cycle and sequences 16-bit word accesses as two byte beats. It tags in-flight reads and returns each read to its requester after the fixed memory latency. It sits between the core/video/debug logic and the memory array.

Parameters:
MEM_LATENCY, 2, cycles from mem_addr_out issue to valid mem_dout_in (≥1)
VIDEO_MAX_WAIT, 8, cycles video may be stalled before it outranks proc

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
proc_valid_in  in  1  proc request
proc_addr_in  in  12  proc byte address
proc_we_in  in  1  1 = write
proc_type_in  in  2  0 byte, 1 word; 2/3 treated as byte
proc_wdata_in  in  16  write data (byte uses [7:0])
proc_ready_out  out  1  proc request accepted this cycle
proc_rvalid_out  out  1  proc read data on data_out
video_valid_in  in  1  video byte read request (read-only)
video_addr_in  in  12  video byte address
video_ready_out  out  1  video request accepted
video_rvalid_out  out  1  video read data on data_out
debug_valid_in  in  1  debug request
debug_addr_in  in  12  debug byte address
debug_we_in  in  1  1 = write
debug_type_in  in  2  as proc_type_in
debug_wdata_in  in  16  write data
debug_ready_out  out  1  debug request accepted
debug_rvalid_out  out  1  debug read data on data_out
data_out  out  16  read data; byte read zero-extended
mem_addr_out  out  12  memory address
mem_we_out  out  1  memory write enable
mem_din_out  out  8  memory write byte
mem_dout_in  in  8  memory read byte, MEM_LATENCY after issue

Behaviour:
- Clock clk_in; reset rst_in is synchronous and active-high.
- FSM states: IDLE, BEAT1.
- IDLE: combinational grant among valid requesters. Priority: debug > proc > video. When video_wait == VIDEO_MAX_WAIT: debug > video > proc.
- Winner's ready_out = 1 in the same cycle; all other readies are 0. Beat 0 is driven on mem_* in that cycle.
- Byte access stays in IDLE, giving one byte access per cycle.
- Word access goes to BEAT1. All readies are 0 in BEAT1. Beat 1 is issued at (latched addr + 1) mod 4096, so 0xFFF wraps to 0x000. Then return to IDLE.
- Words are big-endian: beat 0 carries wdata[15:8] / high byte; beat 1 carries wdata[7:0] / low byte.
- mem_we_out is high only on write beats. mem_addr_out is 0 when no beat is issued.
- Read tag pipeline, depth MEM_LATENCY, entries {valid, id, hi, last}:
  - At tag output, mem_dout_in goes to data_out[15:8] if hi, else to data_out[7:0]. A byte read clears [15:8].
  - On a last beat, the requester's rvalid pulses 1 cycle, in the same cycle data_out becomes valid. That is cycle T+MEM_LATENCY+1 for a byte accepted at cycle T, and +1 more for a word.
  - data_out holds until the next rvalid. Writes produce no rvalid.
  - Back-to-back reads overlap fully.
- video_wait counter:
  - Increments while video_valid_in && !video_ready_out.
  - Saturates at VIDEO_MAX_WAIT.
  - Clears on video accept or when video_valid_in is low.
- Reset values: all ready/rvalid 0, data_out 0, mem_we_out 0, mem_addr_out 0, FSM IDLE, tags cleared, video_wait 0.
- Reset mid-operation: in-flight reads are dropped with no rvalid, and a pending BEAT1 is not issued.
- Requesters hold valid/addr/we/type/wdata stable until ready. Requests must not change while waiting.

Test Plan:
- Byte read at 0x201 via debug after reset (memory model holds 0xE0 at 0x201): debug_ready=1 at cycle T, mem_addr_out=0x201 at T; debug_rvalid=1 and data_out=0x00E0 at T+3.
- Proc word write 0xABCD to 0xFFF: mem_we=1 with addr 0xFFF/din 0xAB, then 0x000/0xCD. A following proc word read of 0xFFF returns data_out=0xABCD, with proc_rvalid at accept+4.
- Debug, proc and video all valid simultaneously: accept order is debug, then proc, then video (byte requests, one per cycle). rvalids follow in the same order.
- Proc valid continuously and video valid: video is stalled 8 cycles, then video_ready=1 on cycle 9 while proc_ready=0; video_wait returns to 0.
- Debug word read accepted, rst_in pulsed during BEAT1: no beat-1 issue, no debug_rvalid, all outputs at reset values the cycle after reset.
- Back-to-back video byte reads at 0x300..0x303: one accept per cycle, and video_rvalid high for 4 consecutive cycles with the matching bytes.
